serial_add_sequencer: RTL and testbench

Bit-serial add/subtract controller that time-shares one single-bit full-adder cell across all bits of a WIDTH-bit operand pair. It sits in the arithmetic unit in front of the adder cell. It captures operands on a start handshake, steps the cell LSB-first for WIDTH cycles, and returns the sum, carry and signed-overflow flags with a one-cycle done pulse. It trades latency for area, replacing a WIDTH-wide ripple adder.

---
 rtl/serial_add_sequencer_if.sv | 24 ++
 rtl/serial_add_sequencer.sv | 99 +++++++++
 tb/tb_serial_add_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_if.sv
// rtl/serial_add_sequencer_if.sv - request/response bundle for the bit-serial add/subtract sequencer
interface serial_add_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add/subtract controller time-sharing one full-adder cell
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    serial_add_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic             cell_sum;
    logic             cell_cout;

    assign cell_sum  = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign cell_cout = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        count_d     = count_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    opa_d       = bus.a;
                    opb_d       = bus.op_sub ? ~bus.b : bus.b;
                    carry_d     = bus.op_sub;
                    count_d     = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                result_d = {cell_sum, result_q[WIDTH-1:1]};
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                carry_d  = cell_cout;
                count_d  = count_q + CW'(1);
                // Flags are registered on the MSB step so they are already valid while done is high.
                if (count_q == CW'(WIDTH - 1)) begin
                    carry_out_d = cell_cout;
                    overflow_d  = carry_q ^ cell_cout;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - self-checking bench for serial_add_sequencer at WIDTH=4
module tb_serial_add_sequencer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.WIDTH(W)) intf ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (intf.slave)
    );

    typedef struct {
        int a;
        int b;
        int sub;
        int exp_r;
        int exp_c;
        int exp_o;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int a, input int b, input int sub,
                         output int r, output int c, output int o);
        int full, sa, sb, s;
        full = sub ? (a + ((~b) & 15) + 1) : (a + b);
        r    = full & 15;
        c    = (full >> 4) & 1;
        sa   = (a >= 8) ? a - 16 : a;
        sb   = (b >= 8) ? b - 16 : b;
        s    = sub ? sa - sb : sa + sb;
        o    = (s > 7 || s < -8) ? 1 : 0;
    endtask

    task automatic do_op(input int a, input int b, input int sub,
                         output int r, output int c, output int o,
                         output int busy_cyc, output int lat);
        @(negedge clk);
        intf.start  = 1'b1;
        intf.a      = 4'(a);
        intf.b      = 4'(b);
        intf.op_sub = sub[0];
        @(posedge clk);
        #1;
        intf.start  = 1'b0;
        intf.a      = 4'($urandom);
        intf.b      = 4'($urandom);
        intf.op_sub = 1'($urandom);
        busy_cyc = 0;
        lat = 0;
        r = -1; c = -1; o = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (intf.busy && intf.done) chk("busy_and_done", 1, 0);
            if (intf.busy) busy_cyc++;
            if (intf.done) begin
                lat = i;
                r = int'(intf.result);
                c = int'(intf.carry_out);
                o = int'(intf.overflow);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r, c, o, bc, lat, er, ec, eo, a, b, s, ndone;
        int t_done[$];

        tbl[0] = '{7, 1, 0, 8, 0, 1};
        tbl[1] = '{15, 1, 0, 0, 1, 0};
        tbl[2] = '{8, 8, 0, 0, 1, 1};
        tbl[3] = '{5, 3, 1, 2, 1, 0};
        tbl[4] = '{3, 5, 1, 14, 0, 0};

        intf.start = 1'b0; intf.a = '0; intf.b = '0; intf.op_sub = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", intf.busy, 0);
        chk("rst_done", intf.done, 0);
        chk("rst_result", intf.result, 0);
        chk("rst_carry", intf.carry_out, 0);
        chk("rst_ovf", intf.overflow, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, r, c, o, bc, lat);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].exp_r);
            chk($sformatf("tbl%0d_carry", i), c, tbl[i].exp_c);
            chk($sformatf("tbl%0d_ovf", i), o, tbl[i].exp_o);
            chk($sformatf("tbl%0d_busycycles", i), bc, W);
            chk($sformatf("tbl%0d_latency", i), lat, W + 1);
            @(negedge clk);
            chk($sformatf("tbl%0d_hold_result", i), intf.result, tbl[i].exp_r);
            chk($sformatf("tbl%0d_hold_done", i), intf.done, 0);
        end

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            s = int'($urandom_range(1, 0));
            model(a, b, s, er, ec, eo);
            do_op(a, b, s, r, c, o, bc, lat);
            chk($sformatf("rnd%0d_result a=%0d b=%0d sub=%0d", i, a, b, s), r, er);
            chk($sformatf("rnd%0d_carry", i), c, ec);
            chk($sformatf("rnd%0d_ovf", i), o, eo);
            chk($sformatf("rnd%0d_latency", i), lat, W + 1);
        end

        // Requests during RUN and DONE are dropped, not queued.
        @(negedge clk);
        intf.start = 1'b1; intf.a = 4'd1; intf.b = 4'd1; intf.op_sub = 1'b0;
        @(posedge clk);
        #1;
        intf.a = 4'd9; intf.b = 4'd9;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (intf.done) begin
                ndone++;
                chk("ign_result_at_done", intf.result, 2);
            end
            intf.start = intf.busy | intf.done;
        end
        intf.start = 1'b0;
        chk("ign_done_count", ndone, 1);
        chk("ign_hold_result", intf.result, 2);
        chk("ign_idle_busy", intf.busy, 0);

        // Reset in the 2nd RUN cycle clears everything at once and loses the operation.
        @(negedge clk);
        intf.start = 1'b1; intf.a = 4'd5; intf.b = 4'd0; intf.op_sub = 1'b0;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy_before", intf.busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrun_busy", intf.busy, 0);
        chk("midrun_done", intf.done, 0);
        chk("midrun_result", intf.result, 0);
        chk("midrun_carry", intf.carry_out, 0);
        chk("midrun_ovf", intf.overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (intf.done || intf.busy) ndone++;
        end
        chk("midrun_no_resume", ndone, 0);
        do_op(6, 2, 0, r, c, o, bc, lat);
        chk("after_rst_result", r, 8);
        chk("after_rst_latency", lat, W + 1);

        // start held high: back-to-back ops every WIDTH+2 cycles.
        @(negedge clk);
        intf.start = 1'b1; intf.a = 4'd2; intf.b = 4'd3; intf.op_sub = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (intf.done) begin
                t_done.push_back(i);
                chk("held_result", intf.result, 5);
            end
        end
        intf.start = 1'b0;
        chk("held_done_count_ge3", (t_done.size() >= 3) ? 1 : 0, 1);
        if (t_done.size() >= 3) begin
            chk("held_gap1", t_done[1] - t_done[0], W + 2);
            chk("held_gap2", t_done[2] - t_done[1], W + 2);
        end

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
